spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- Mode-0 (CPOL=0, CPHA=0), MSB-first SPI slave.
- It is the far end of the team's SPI_Master: it receives MOSI bytes and returns MISO bytes.
- It oversamples the asynchronous SCLK, MOSI and SS in the system clock domain. Byte data is exchanged through a one-deep transmit holding register and a receive register with a done strobe.
- It sits on the peripheral side of the SPI link and feeds a local register file or FIFO.

Parameters:
- DATA_WIDTH, 8, bits per SPI word. The bit counter is $clog2(DATA_WIDTH) bits wide.
- SYNC_STAGES, 2, number of flip-flops in each synchronizer for SCLK, MOSI and SS. Minimum 2.
- IDLE_BYTE, 8'hFF, word shifted out on MISO when the holding register is empty at a word boundary.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- SCLK  input  1  SPI clock from master; asynchronous to clk.
- MOSI  input  1  serial data from master; asynchronous to clk.
- SS  input  1  slave select, active low; asynchronous to clk.
- MISO  output  1  serial data to master.
- tx_data  input  DATA_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty; a word is accepted when tx_valid && tx_ready.
- rx_data  output  DATA_WIDTH  last complete received word; held until the next word completes.
- done  output  1  one-clk pulse when rx_data has been updated.
- busy  output  1  frame active (synchronized SS low).

Behaviour:
- Reset values (asynchronous reset): MISO=0, tx_ready=1, rx_data=0, done=0, busy=0. Holding register empty, bit_cnt=0, state IDLE.
- Reset asserted mid-frame aborts everything immediately. After release the block waits for a fresh SS falling edge.
- Synchronization: SCLK, MOSI and SS each pass through SYNC_STAGES flops.
  - Edges are detected against one extra registered copy.
  - Pin-to-internal-event latency is SYNC_STAGES+1 clk.
- Timing requirement on the master: SCLK high and low times must each be at least 4 clk, and SS setup before the first rise must be at least 4 clk.
- FSM state IDLE (SS high):
  - MISO=0 and busy=0.
  - On a synchronized SS falling edge: go to ACTIVE, bit_cnt=0, load the shift register from the holding register (or IDLE_BYTE if empty), and drive MISO = shift MSB in the same cycle.
- FSM state ACTIVE:
  - SCLK rise: rx_shift <= {rx_shift[DATA_WIDTH-2:0], MOSI_sync}; bit_cnt increments.
  - On the rise where bit_cnt == DATA_WIDTH-1: rx_data <= the completed word, done=1 for exactly one clk on the next cycle, and bit_cnt wraps to 0.
  - SCLK fall with bit_cnt != 0: shift tx left; MISO = new MSB.
  - SCLK fall with bit_cnt == 0 (word boundary, back-to-back transfer): load the next word from the holding register (or IDLE_BYTE); MISO = its MSB.
- Holding-register handshake:
  - tx_valid && tx_ready captures tx_data; tx_ready drops on the next clk.
  - A transfer of the holding register into the shift register empties it; tx_ready rises on the next clk.
  - tx_valid while tx_ready=0 is ignored, and the holding contents are unchanged.
  - Same-cycle boundary load and tx_valid with the holding register empty: the shift register gets IDLE_BYTE and tx_data is captured into the holding register for the following word.
- SS rising edge (synchronized) while ACTIVE:
  - Return to IDLE and clear bit_cnt.
  - A partial rx word is discarded: no done, rx_data unchanged.
  - The tx word already in the shift register is consumed, not restored. The holding register is untouched.
- Simultaneous SS rise and SCLK rise in the same clk: the SS rise wins and no bit is sampled.
- SCLK edges while in IDLE are ignored.
- rx_data is overwritten on each completed word. There is no overrun flag; the consumer must read within one word time.

Test Plan:
- Preload tx 8'hA5, assert SS, master shifts 8'h3C mode 0 (SCLK half-period 5 clk) -> MISO bits 1,0,1,0,0,1,0,1 sampled on SCLK rises; rx_data=8'h3C; done high exactly 1 clk; tx_ready returns to 1.
- Back-to-back in one SS frame: master sends 8'hA5 then 8'h5A. Load tx 8'h3C, then load 8'hC3 after tx_ready rises -> MISO returns 8'h3C then 8'hC3; two done pulses; rx_data 8'hA5 then 8'h5A.
- No tx loaded, master sends 8'h00 -> MISO returns 8'hFF (IDLE_BYTE); rx_data=8'h00; done pulses.
- SS deasserted after 3 SCLK rises -> no done, rx_data keeps its previous value, busy drops. A following full frame with 8'h5A -> rx_data=8'h5A.
- tx_valid pulsed with 8'h11 while the holding register is full with 8'h22 -> 8'h22 transmitted; 8'h11 never appears on MISO.
- Reset asserted at bit 4 of a frame -> all outputs return to reset values asynchronously. After release plus a new SS frame with 8'h3C -> rx_data=8'h3C, done pulses once.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: mode-0 (CPOL=0, CPHA=0), MSB-first SPI slave.
// SCLK, MOSI and SS are oversampled in the clk domain. Words are exchanged
// through a one-deep transmit holding register and a receive register with
// a one-clk done strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | SS high (or no fresh SS fall seen); MISO=0, SCLK ignored
// ACTIVE | frame open; sample MOSI on SCLK rise, shift MISO on fall
module spi_slave #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SS,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  done,
  output logic                  busy
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains plus one delayed copy for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  logic sclk_s;
  logic mosi_s;
  logic ss_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;

  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q,  tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q,  rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
  logic [DATA_WIDTH-1:0] hold_q,      hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  done_q,      done_d;
  logic                  miso_q,      miso_d;
  logic                  load_word;

  // Bring the asynchronous pins into the clk domain. SS resets low so that
  // a reset released mid-frame only restarts on a genuinely new SS fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
      miso_q      <= miso_d;
    end
  end

  // Next-state, shift/sample logic and holding-register handshake.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    miso_d      = miso_q;
    load_word   = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          load_word  = 1'b1;
        end
      end
      ACTIVE: begin
        // SS rise has priority over a coincident SCLK edge; the partial
        // word is dropped and the current tx word is considered consumed.
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            done_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != CNT_ZERO) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end else begin
            load_word = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Word boundary: take the holding register, or the idle pattern if empty.
    if (load_word) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
      end
      miso_d = tx_shift_d[DATA_WIDTH-1];
    end

    // Capture only into an empty holding register; a word offered in the
    // same cycle as an empty-register boundary load waits for the next word.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign MISO     = miso_q;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign done     = done_q;
  assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model with hand-computed
// expected MISO/rx words, done pulse counts and handshake levels.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       clk;
  logic       reset;
  logic       SCLK;
  logic       MOSI;
  logic       SS;
  logic       MISO;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       done;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  int done_cnt = 0;
  int long_cnt = 0;
  logic done_prev = 1'b0;

  spi_slave #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .IDLE_BYTE  (8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .SS      (SS),
    .MISO    (MISO),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses and any pulse that lasts longer than one clk.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (done && done_prev) long_cnt <= long_cnt + 1;
    done_prev <= done;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    SS = 1'b0;
    wait_clk(6);
  endtask

  task automatic ss_end();
    wait_clk(6);
    SS = 1'b1;
    wait_clk(8);
  endtask

  // Mode-0 master: drive MOSI while SCLK low, sample MISO at the rise.
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = mo[7-i];
      wait_clk(5);
      SCLK = 1'b1;
      mi = {mi[6:0], MISO};
      wait_clk(5);
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] mo, output logic [7:0] mi);
    ss_begin();
    spi_bits(mo, 8, mi);
    ss_end();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_total++; if (MISO !== 1'b0) $display("FAIL reset_miso got %b want 0", MISO); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b want 1", tx_ready); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    n_total++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] mi;
    int d0, l0;
    tx_push(8'hA5);
    n_total++; if (tx_ready !== 1'b0) $display("FAIL single_tx_ready_low got %b want 0", tx_ready); else n_pass++;
    d0 = done_cnt; l0 = long_cnt;
    ss_begin();
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else n_pass++;
    spi_bits(8'h3C, 8, mi);
    ss_end();
    n_total++; if (mi !== 8'hA5) $display("FAIL single_miso got %h want a5", mi); else n_pass++;
    n_total++; if (rx_data !== 8'h3C) $display("FAIL single_rx got %h want 3c", rx_data); else n_pass++;
    n_total++; if (done_cnt - d0 !== 1) $display("FAIL single_done_count got %0d want 1", done_cnt - d0); else n_pass++;
    n_total++; if (long_cnt - l0 !== 0) $display("FAIL single_done_width got %0d long pulses want 0", long_cnt - l0); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL single_tx_ready_high got %b want 1", tx_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_drop got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi;
    int d0, waited;
    tx_push(8'h3C);
    d0 = done_cnt;
    ss_begin();
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 20) begin
      wait_clk(1);
      waited++;
    end
    n_total++; if (tx_ready !== 1'b1) $display("FAIL b2b_tx_ready_timeout got %b want 1", tx_ready); else n_pass++;
    tx_push(8'hC3);
    spi_bits(8'hA5, 8, mi);
    n_total++; if (mi !== 8'h3C) $display("FAIL b2b_miso0 got %h want 3c", mi); else n_pass++;
    n_total++; if (rx_data !== 8'hA5) $display("FAIL b2b_rx0 got %h want a5", rx_data); else n_pass++;
    spi_bits(8'h5A, 8, mi);
    n_total++; if (mi !== 8'hC3) $display("FAIL b2b_miso1 got %h want c3", mi); else n_pass++;
    ss_end();
    n_total++; if (rx_data !== 8'h5A) $display("FAIL b2b_rx1 got %h want 5a", rx_data); else n_pass++;
    n_total++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_idle_byte();
    logic [7:0] mi;
    int d0;
    d0 = done_cnt;
    spi_frame(8'h00, mi);
    n_total++; if (mi !== 8'hFF) $display("FAIL idle_miso got %h want ff", mi); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL idle_rx got %h want 00", rx_data); else n_pass++;
    n_total++; if (done_cnt - d0 !== 1) $display("FAIL idle_done_count got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_partial();
    logic [7:0] mi;
    int d0;
    d0 = done_cnt;
    ss_begin();
    spi_bits(8'hE0, 3, mi);
    ss_end();
    n_total++; if (done_cnt - d0 !== 0) $display("FAIL partial_done_count got %0d want 0", done_cnt - d0); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL partial_rx_kept got %h want 00", rx_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL partial_busy got %b want 0", busy); else n_pass++;
    d0 = done_cnt;
    spi_frame(8'h5A, mi);
    n_total++; if (rx_data !== 8'h5A) $display("FAIL partial_next_rx got %h want 5a", rx_data); else n_pass++;
    n_total++; if (done_cnt - d0 !== 1) $display("FAIL partial_next_done got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_tx_ignore();
    logic [7:0] mi;
    tx_push(8'h22);
    n_total++; if (tx_ready !== 1'b0) $display("FAIL ignore_tx_ready got %b want 0", tx_ready); else n_pass++;
    tx_push(8'h11);
    spi_frame(8'h96, mi);
    n_total++; if (mi !== 8'h22) $display("FAIL ignore_miso got %h want 22", mi); else n_pass++;
    n_total++; if (rx_data !== 8'h96) $display("FAIL ignore_rx got %h want 96", rx_data); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL ignore_tx_ready_after got %b want 1", tx_ready); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    int d0;
    ss_begin();
    tx_push(8'h44);
    spi_bits(8'h3C, 4, mi);
    n_total++; if (tx_ready !== 1'b0) $display("FAIL mid_tx_ready_pre got %b want 0", tx_ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_pre got %b want 1", busy); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (MISO !== 1'b0) $display("FAIL mid_miso got %b want 0", MISO); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL mid_tx_ready got %b want 1", tx_ready); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL mid_rx got %h want 00", rx_data); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL mid_done got %b want 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else n_pass++;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(6);
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy_after_release got %b want 0", busy); else n_pass++;
    SS = 1'b1;
    wait_clk(8);
    d0 = done_cnt;
    spi_frame(8'h3C, mi);
    n_total++; if (mi !== 8'hFF) $display("FAIL mid_next_miso got %h want ff", mi); else n_pass++;
    n_total++; if (rx_data !== 8'h3C) $display("FAIL mid_next_rx got %h want 3c", rx_data); else n_pass++;
    n_total++; if (done_cnt - d0 !== 1) $display("FAIL mid_next_done got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    SCLK     = 1'b0;
    MOSI     = 1'b0;
    SS       = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_idle_byte();
    test_partial();
    test_tx_ignore();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
